// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: op codes and shared constants for the pipelined vector ALU
package vec_alu_pkg;
   localparam int OP_W    = 3;
   localparam int SHAMT_W = 5;
   typedef enum logic [OP_W-1:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MOVB
   } op_t;
endpackage

// File: rtl/vec_alu_lane.sv
// vec_alu_lane: one unsigned ALU lane, forced to zero when the lane is disabled
module vec_alu_lane
   import vec_alu_pkg::*;
#(
   parameter int LANE_W = 32
) (
   input  logic [LANE_W-1:0] a_lane,
   input  logic [LANE_W-1:0] b_lane,
   input  op_t               op,
   input  logic              sat,
   input  logic              en_lane,
   output logic [LANE_W-1:0] res_lane
);
   logic [LANE_W:0]   w_sum;
   logic [LANE_W:0]   w_diff;
   logic [LANE_W-1:0] w_mul;
   logic [LANE_W-1:0] w_res;
   assign w_sum  = {1'b0, a_lane} + {1'b0, b_lane};
   assign w_diff = {1'b0, a_lane} - {1'b0, b_lane};
   assign w_mul  = a_lane * b_lane;
   // per-op result; the extra top bit of sum/diff is the carry/borrow used for clamping
   always_comb begin
      w_res = '0;
      case (op)
         OP_ADD:  w_res = (sat & w_sum[LANE_W]) ? '1 : w_sum[LANE_W-1:0];
         OP_SUB:  w_res = (sat & w_diff[LANE_W]) ? '0 : w_diff[LANE_W-1:0];
         OP_MUL:  w_res = w_mul;
         OP_AND:  w_res = a_lane & b_lane;
         OP_OR:   w_res = a_lane | b_lane;
         OP_XOR:  w_res = a_lane ^ b_lane;
         OP_SHL:  w_res = a_lane << b_lane[SHAMT_W-1:0];
         default: w_res = b_lane;
      endcase
   end
   assign res_lane = en_lane ? w_res : '0;
endmodule

// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: lane-configurable vector ALU with a fixed-shift valid/ready pipeline and flush
module vec_alu_pipe
   import vec_alu_pkg::*;
#(
   parameter int LANES  = 6,
   parameter int LANE_W = 32,
   parameter int LAT    = 2,
   parameter int TAG_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   input  logic [OP_W-1:0]         op,
   input  logic                    vec,
   input  logic                    bcast,
   input  logic                    sat,
   input  logic [LANES*LANE_W-1:0] a,
   input  logic [LANES*LANE_W-1:0] b,
   input  logic [TAG_W-1:0]        tag_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] result,
   output logic                    flag_z,
   output logic [TAG_W-1:0]        tag_out
);
   localparam int DW = LANES * LANE_W;
   typedef struct packed {
      logic             valid;
      logic             zero;
      logic [TAG_W-1:0] tag;
      logic [DW-1:0]    data;
   } stage_t;
   stage_t        r_st [LAT];
   logic          w_en;
   logic          w_acc;
   logic [DW-1:0] w_res;
   assign w_en     = out_ready | ~r_st[LAT-1].valid;
   assign in_ready = w_en;
   assign w_acc    = in_valid & w_en & ~flush;
   genvar i;
   for (i = 0; i < LANES; i++) begin : g_lane
      vec_alu_lane #(.LANE_W(LANE_W)) u_lane (
         .a_lane   (a[i*LANE_W +: LANE_W]),
         .b_lane   (bcast ? b[LANE_W-1:0] : b[i*LANE_W +: LANE_W]),
         .op       (op_t'(op)),
         .sat      (sat),
         .en_lane  (vec | (i == 0)),
         .res_lane (w_res[i*LANE_W +: LANE_W])
      );
   end
   // stage shift: reset clears everything, flush kills valids, otherwise advance together on en
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) r_st[k] <= '0;
      end else if (flush) begin
         for (int k = 0; k < LAT; k++) r_st[k].valid <= 1'b0;
      end else if (w_en) begin
         r_st[0] <= '{valid: w_acc, zero: ~|w_res, tag: tag_in, data: w_res};
         for (int k = 1; k < LAT; k++) r_st[k] <= r_st[k-1];
      end
   end
   assign out_valid = r_st[LAT-1].valid;
   assign result    = r_st[LAT-1].data;
   assign flag_z    = r_st[LAT-1].zero;
   assign tag_out   = r_st[LAT-1].tag;
endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb_vec_alu_pipe: table-driven scoreboard bench for vec_alu_pipe (6 lanes x 32 bits, LAT=2)
module tb_vec_alu_pipe;
   import vec_alu_pkg::*;
   localparam int DW = 192;
   localparam int NV = 14;
   typedef struct {
      logic [2:0]    op;
      logic          vec, bcast, sat;
      logic [DW-1:0] a, b;
      logic [3:0]    tag;
      logic [DW-1:0] res;
      logic          z;
   } vec_t;
   typedef struct {
      logic [DW-1:0] res;
      logic          z;
      logic [3:0]    tag;
   } exp_t;
   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, flush, vec, bcast, sat, out_valid, out_ready, flag_z;
   logic [2:0]    op;
   logic [DW-1:0] a, b, result;
   logic [3:0]    tag_in, tag_out;
   int            tests = 0;
   int            fails = 0;
   exp_t          q[$];
   exp_t          m_e;
   vec_t          tv[NV];
   vec_alu_pipe #(.LANES(6), .LANE_W(32), .LAT(2), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .op(op), .vec(vec), .bcast(bcast), .sat(sat), .a(a), .b(b), .tag_in(tag_in),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .flag_z(flag_z),
      .tag_out(tag_out)
   );
   always #5 clk = ~clk;
   function automatic logic [DW-1:0] L6(input logic [31:0] x0, x1, x2, x3, x4, x5);
      return {x5, x4, x3, x2, x1, x0};
   endfunction
   function automatic vec_t mk(input logic [2:0] o, input logic v, bc, s,
                               input logic [DW-1:0] a_, b_, input logic [3:0] t,
                               input logic [DW-1:0] r, input logic z);
      vec_t x;
      x.op = o; x.vec = v; x.bcast = bc; x.sat = s; x.a = a_; x.b = b_;
      x.tag = t; x.res = r; x.z = z;
      return x;
   endfunction
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   task automatic send(input vec_t v, input bit push);
      int n = 0;
      op = v.op; vec = v.vec; bcast = v.bcast; sat = v.sat;
      a = v.a; b = v.b; tag_in = v.tag; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: in_ready stuck at 0 for tag %0d", v.tag);
      end else if (push) q.push_back('{v.res, v.z, v.tag});
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("drain_empty", DW'(q.size()), DW'(0));
      @(posedge clk); #1;
   endtask
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out: got tag %0d result %h want no result", tag_out, result);
         end else begin
            m_e = q.pop_front();
            chk("result", result, m_e.res);
            chk("flag_z", DW'(flag_z), DW'(m_e.z));
            chk("tag_out", DW'(tag_out), DW'(m_e.tag));
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      tv[0]  = mk(OP_ADD, 1, 0, 0, L6(1, 2, 3, 4, 5, 6), L6(10, 20, 30, 40, 50, 60), 4'd1,
                  L6(11, 22, 33, 44, 55, 66), 1'b0);
      tv[1]  = mk(OP_ADD, 1, 0, 1, L6(32'hFFFFFFF0, 32'hFFFFFFFE, 1, 1, 1, 1), L6(32'h20, 1, 2, 2, 2, 2), 4'd2,
                  L6(32'hFFFFFFFF, 32'hFFFFFFFF, 3, 3, 3, 3), 1'b0);
      tv[2]  = mk(OP_ADD, 1, 0, 0, L6(32'hFFFFFFF0, 32'hFFFFFFFE, 1, 1, 1, 1), L6(32'h20, 1, 2, 2, 2, 2), 4'd3,
                  L6(32'h10, 32'hFFFFFFFF, 3, 3, 3, 3), 1'b0);
      tv[3]  = mk(OP_SUB, 0, 0, 1, L6(5, 8, 8, 8, 8, 8), L6(9, 1, 1, 1, 1, 1), 4'd4,
                  L6(0, 0, 0, 0, 0, 0), 1'b1);
      tv[4]  = mk(OP_SUB, 0, 0, 0, L6(5, 8, 8, 8, 8, 8), L6(9, 1, 1, 1, 1, 1), 4'd5,
                  L6(32'hFFFFFFFC, 0, 0, 0, 0, 0), 1'b0);
      tv[5]  = mk(OP_MOVB, 0, 1, 0, L6(1, 1, 1, 1, 1, 1), L6(7, 99, 99, 99, 99, 99), 4'd6,
                  L6(7, 0, 0, 0, 0, 0), 1'b0);
      tv[6]  = mk(OP_MOVB, 0, 1, 0, L6(1, 1, 1, 1, 1, 1), L6(0, 99, 99, 99, 99, 99), 4'd7,
                  L6(0, 0, 0, 0, 0, 0), 1'b1);
      tv[7]  = mk(OP_MUL, 1, 0, 0, L6(3, 32'h10000, 32'hFFFFFFFF, 0, 7, 100), L6(5, 32'h10000, 2, 9, 6, 100), 4'd8,
                  L6(15, 0, 32'hFFFFFFFE, 0, 42, 10000), 1'b0);
      tv[8]  = mk(OP_AND, 1, 0, 1, L6(32'hFF00FF00, 32'h12345678, 0, 32'hFFFFFFFF, 32'hA, 32'hC),
                  L6(32'h0FF00FF0, 32'hFFFF0000, 1, 32'h1234, 6, 5), 4'd9,
                  L6(32'h0F000F00, 32'h12340000, 0, 32'h1234, 2, 4), 1'b0);
      tv[9]  = mk(OP_OR, 1, 0, 0, L6(32'hFF00FF00, 32'h12345678, 0, 32'hFFFFFFFF, 32'hA, 32'hC),
                  L6(32'h0FF00FF0, 32'hFFFF0000, 1, 32'h1234, 6, 5), 4'd10,
                  L6(32'hFFF0FFF0, 32'hFFFF5678, 1, 32'hFFFFFFFF, 32'hE, 32'hD), 1'b0);
      tv[10] = mk(OP_XOR, 1, 0, 1, L6(32'hFF00FF00, 32'h12345678, 0, 32'hFFFFFFFF, 32'hA, 32'hC),
                  L6(32'h0FF00FF0, 32'hFFFF0000, 1, 32'h1234, 6, 5), 4'd11,
                  L6(32'hF0F0F0F0, 32'hEDCB5678, 1, 32'hFFFFEDCB, 32'hC, 32'h9), 1'b0);
      tv[11] = mk(OP_SHL, 1, 1, 0, L6(1, 2, 3, 32'h80000001, 32'hF, 32'hFFFF), L6(4, 9, 9, 9, 9, 9), 4'd12,
                  L6(16, 32, 48, 32'h10, 32'hF0, 32'hFFFF0), 1'b0);
      tv[12] = mk(OP_SHL, 1, 0, 0, L6(1, 5, 5, 5, 32'hFFFFFFFF, 3), L6(31, 0, 1, 32'h21, 31, 32'hE0), 4'd13,
                  L6(32'h80000000, 5, 10, 10, 32'h80000000, 3), 1'b0);
      tv[13] = mk(OP_MOVB, 1, 1, 0, L6(1, 1, 1, 1, 1, 1), L6(7, 99, 99, 99, 99, 99), 4'd14,
                  L6(7, 7, 7, 7, 7, 7), 1'b0);
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      op = '0; vec = 1'b0; bcast = 1'b0; sat = 1'b0; a = '0; b = '0; tag_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_result", result, DW'(0));
      chk("rst_flag_z", DW'(flag_z), DW'(0));
      chk("rst_tag_out", DW'(tag_out), DW'(0));
      chk("rst_in_ready", DW'(in_ready), DW'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      send(tv[0], 1'b1);
      @(negedge clk);
      chk("lat_early", DW'(out_valid), DW'(0));
      @(negedge clk);
      chk("lat_on_time", DW'(out_valid), DW'(1));
      drain();
      for (int k = 0; k < NV; k++) send(tv[k], 1'b1);
      drain();
      fork
         begin
            for (int k = 0; k < 4; k++) send(tv[k], 1'b1);
         end
         begin
            int n = 0;
            logic [DW-1:0] held;
            logic [3:0] held_tag;
            while (!out_valid && n < 20) begin
               @(posedge clk); #1;
               n++;
            end
            chk("bp_first_out", DW'(out_valid), DW'(1));
            out_ready = 1'b0;
            held = result;
            held_tag = tag_out;
            repeat (3) begin
               @(negedge clk);
               chk("bp_in_ready", DW'(in_ready), DW'(0));
               chk("bp_hold_valid", DW'(out_valid), DW'(1));
               chk("bp_hold_result", result, held);
               chk("bp_hold_tag", DW'(tag_out), DW'(held_tag));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      out_ready = 1'b0;
      send(tv[5], 1'b0);
      send(tv[6], 1'b0);
      op = tv[7].op; vec = tv[7].vec; bcast = tv[7].bcast; sat = tv[7].sat;
      a = tv[7].a; b = tv[7].b; tag_in = tv[7].tag;
      in_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("fl_stalled_valid", DW'(out_valid), DW'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("fl_cleared", DW'(out_valid), DW'(0));
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("fl_stay_empty", DW'(out_valid), DW'(0));
      end
      @(posedge clk); #1;
      send(tv[8], 1'b1);
      @(negedge clk);
      chk("fl_after_early", DW'(out_valid), DW'(0));
      @(negedge clk);
      chk("fl_after_on_time", DW'(out_valid), DW'(1));
      drain();
      op = tv[9].op; a = tv[9].a; b = tv[9].b; tag_in = tv[9].tag;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("fl_ready_drop", DW'(out_valid), DW'(0));
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(tv[0], 1'b0);
      send(tv[1], 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_pre_valid", DW'(out_valid), DW'(1));
      @(negedge clk);
      chk("mid_out_valid", DW'(out_valid), DW'(0));
      chk("mid_result", result, DW'(0));
      chk("mid_flag_z", DW'(flag_z), DW'(0));
      chk("mid_tag_out", DW'(tag_out), DW'(0));
      chk("mid_in_ready", DW'(in_ready), DW'(1));
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      chk("final_queue", DW'(q.size()), DW'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
